// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/exception controller.
package pipe_ctrl_pkg;

    localparam int unsigned NUM_REGS = 5;
    localparam int unsigned ADDR_W   = 32;

    // Bit positions of the pipeline registers in stall/flush vectors
    localparam int unsigned PC_IDX     = 0;
    localparam int unsigned IFID_IDX   = 1;
    localparam int unsigned IDEXE_IDX  = 2;
    localparam int unsigned EXEMEM_IDX = 3;
    localparam int unsigned WB_IDX     = 4;

    typedef enum logic [1:0] {
        RUN,
        WAIT_MEM,
        FLUSH,
        HOLD
    } state_t;

    typedef struct packed {
        logic mem_req;
        logic exe_req;
        logic id_req;
        logic if_req;
    } stall_req_t;

    // ERET returns to the saved PC, any other exception enters the handler
    function automatic logic [ADDR_W-1:0] exc_target(input logic              eret,
                                                     input logic [ADDR_W-1:0] handler,
                                                     input logic [ADDR_W-1:0] epc);
        return eret ? epc : handler;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline and its controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                if_stall_req_i;
    logic                id_stall_req_i;
    logic                exe_stall_req_i;
    logic                mem_stall_req_i;
    logic                exc_valid_i;
    logic                eret_i;
    logic [ADDR_W-1:0]   exc_handler_i;
    logic [ADDR_W-1:0]   epc_i;
    logic [NUM_REGS-1:0] stall_o;
    logic [NUM_REGS-1:0] flush_o;
    logic                redirect_valid_o;
    logic [ADDR_W-1:0]   redirect_pc_o;
    logic                stall_timeout_o;

    modport master (
        output if_stall_req_i, id_stall_req_i, exe_stall_req_i, mem_stall_req_i,
        output exc_valid_i, eret_i, exc_handler_i, epc_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, stall_timeout_o
    );

    modport slave (
        input  if_stall_req_i, id_stall_req_i, exe_stall_req_i, mem_stall_req_i,
        input  exc_valid_i, eret_i, exc_handler_i, epc_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o, stall_timeout_o
    );

endinterface

// File: rtl/stall_decode.sv
// Deepest-requesting-stage priority: hold every register up to it, bubble the next one.
module stall_decode
    import pipe_ctrl_pkg::*;
(
    input  stall_req_t          req,
    output logic [NUM_REGS-1:0] stall,
    output logic [NUM_REGS-1:0] flush
);

    always_comb begin
        stall = '0;
        flush = '0;
        if (req.mem_req) begin
            stall = 5'b01111;
            flush = 5'b10000;
        end else if (req.exe_req) begin
            stall = 5'b00111;
            flush = 5'b01000;
        end else if (req.id_req) begin
            stall = 5'b00011;
            flush = 5'b00100;
        end else if (req.if_req) begin
            stall = 5'b00001;
            flush = 5'b00010;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation, exception redirect sequencing
// and a sticky watchdog for stalls that never clear.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 1023
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pend_pc, pend_pc_next;
    logic [ADDR_W-1:0]   exc_pc;
    logic [CNT_W-1:0]    stall_cnt, stall_cnt_next;
    logic                stall_timeout;
    stall_req_t          req;
    logic [NUM_REGS-1:0] dec_stall, dec_flush;
    logic [NUM_REGS-1:0] stall, flush;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;

    assign req.if_req  = bus.if_stall_req_i;
    assign req.id_req  = bus.id_stall_req_i;
    assign req.exe_req = bus.exe_stall_req_i;
    assign req.mem_req = bus.mem_stall_req_i;
    assign exc_pc      = exc_target(bus.eret_i, bus.exc_handler_i, bus.epc_i);

    stall_decode u_stall_decode (
        .req   (req),
        .stall (dec_stall),
        .flush (dec_flush)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pend_pc <= '0;
        end else begin
            state   <= state_next;
            pend_pc <= pend_pc_next;
        end
    end

    // Exception sequencing; a blocked MEM stage defers the redirect until it drains
    always_comb begin
        state_next     = state;
        pend_pc_next   = pend_pc;
        stall          = dec_stall;
        flush          = dec_flush;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            RUN: begin
                if (bus.exc_valid_i) begin
                    if (bus.mem_stall_req_i) begin
                        pend_pc_next = exc_pc;
                        state_next   = WAIT_MEM;
                    end else begin
                        stall          = '0;
                        flush          = '1;
                        redirect_valid = 1'b1;
                        redirect_pc    = exc_pc;
                        state_next     = HOLD;
                    end
                end
            end
            WAIT_MEM: begin
                if (!bus.mem_stall_req_i) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                stall          = '0;
                flush          = '1;
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc;
                state_next     = HOLD;
            end
            HOLD: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (rst) begin
            stall          = '0;
            flush          = '1;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

    always_comb begin
        stall_cnt_next = '0;
        if (stall[PC_IDX]) begin
            stall_cnt_next = (stall_cnt == CNT_W'(STALL_LIMIT)) ? stall_cnt
                                                                : stall_cnt + CNT_W'(1);
        end
    end

    // Timeout flags on the same edge the count reaches the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            if (stall_cnt_next == CNT_W'(STALL_LIMIT)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    assign bus.stall_o          = stall;
    assign bus.flush_o          = flush;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_pc;
    assign bus.stall_timeout_o  = stall_timeout;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter STALL_LIMIT, default 1023; it sets the consecutive-stall cycle count that flags a timeout.
REQ-002 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide if_stall_req_i, id_stall_req_i, exe_stall_req_i, mem_stall_req_i  input  1 each  per-stage stall requests (icache miss, load-use, multi-cycle ALU, dcache miss).
REQ-005 SHALL provide exc_valid_i  input  1  exception or ERET present in MEM stage.
REQ-006 SHALL provide eret_i  input  1  qualifies exc_valid_i as ERET.
REQ-007 SHALL provide exc_handler_i, epc_i  input  32 each  handler address and return address.
REQ-008 SHALL provide stall_o  output  5  hold per register: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM, [4] MEM/WB.
REQ-009 SHALL provide flush_o  output  5  bubble/clear per register, same index map; flush overrides stall in the registers.
REQ-010 SHALL provide redirect_valid_o  output  1  PC redirect strobe.
REQ-011 SHALL provide redirect_pc_o  output  32  redirect target.
REQ-012 SHALL provide stall_timeout_o  output  1  sticky flag: stall held for STALL_LIMIT cycles.

Function
REQ-013 SHALL, in state RUN with no exception, select the deepest requesting stage k (IF=0, ID=1, EXE=2, MEM=3), drive stall_o[0..k]=1 and flush_o[k+1]=1, and drive all other bits 0.
REQ-014 SHALL drive stall_o=0 and flush_o=0 when no request is active.
REQ-015 SHALL, in RUN when exc_valid_i=1 and mem_stall_req_i=0, drive in the same cycle: flush_o=5'b11111, stall_o=0, redirect_valid_o=1, and redirect_pc_o = epc_i if eret_i=1, else exc_handler_i; the state then moves to HOLD.
REQ-016 SHALL, in RUN when exc_valid_i=1 and mem_stall_req_i=1, latch the target into pend_pc, apply REQ-013 stalls, and move to WAIT_MEM.
REQ-017 SHALL, in WAIT_MEM, keep stall_o=5'b01111 and flush_o=5'b10000 while mem_stall_req_i=1, ignoring exc_valid_i.
REQ-018 SHALL move from WAIT_MEM to FLUSH on the first cycle in which mem_stall_req_i=0.
REQ-019 SHALL, in FLUSH (exactly 1 cycle), drive flush_o=5'b11111, stall_o=0, redirect_valid_o=1 and redirect_pc_o=pend_pc, then move to HOLD.
REQ-020 SHALL, in HOLD (exactly 1 cycle), ignore exc_valid_i, apply REQ-013 to the requests, and return to RUN.
REQ-021 SHALL hold redirect_pc_o at 0 whenever redirect_valid_o=0.
REQ-022 SHALL increment stall_cnt (width clog2(STALL_LIMIT+1), saturating) in every cycle with stall_o[0]=1, and clear it in any cycle with stall_o[0]=0.
REQ-023 SHALL set stall_timeout_o when stall_cnt reaches STALL_LIMIT; it stays set until reset.
REQ-024 SHALL give exception handling precedence over the stall requests of IF, ID and EXE in the same cycle.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force: state=RUN, pend_pc=0, stall_cnt=0, stall_timeout_o=0.
REQ-026 SHALL drive stall_o=0, flush_o=5'b11111, redirect_valid_o=0 and redirect_pc_o=0 while rst=1.
REQ-027 SHALL, on reset asserted in WAIT_MEM or FLUSH, discard the pending redirect; no redirect appears after reset release.

Structure
REQ-028 SHALL place the following in shared package pipe_ctrl_pkg: state enum {RUN, WAIT_MEM, FLUSH, HOLD}, stage index constants (PC_IDX..WB_IDX), and NUM_REGS=5.
REQ-029 SHALL implement the REQ-013 priority mapping in one combinational sub-module, stall_decode, reused in RUN, WAIT_MEM and HOLD.

Verification
REQ-030 SHALL cover: id_stall_req_i=1 alone -> stall_o=5'b00011, flush_o=5'b00100.
REQ-031 SHALL cover: if_stall_req_i=1 and exe_stall_req_i=1 together -> stall_o=5'b00111, flush_o=5'b01000.
REQ-032 SHALL cover: exc_valid_i=1, eret_i=0, exc_handler_i=32'hBFC00380, no stall -> same-cycle flush_o=5'b11111, redirect 32'hBFC00380; a second exc_valid_i in the next (HOLD) cycle is ignored.
REQ-033 SHALL cover: exc_valid_i=1, eret_i=1, epc_i=32'h80001000 with mem_stall_req_i=1 for 3 cycles -> 3 cycles stall_o=5'b01111, then 1 FLUSH cycle with redirect 32'h80001000.
REQ-034 SHALL cover: STALL_LIMIT=8, mem_stall_req_i held 8 cycles -> stall_timeout_o=1 and stays set after the request drops.
REQ-035 SHALL cover: rst asserted mid-WAIT_MEM -> outputs reach reset values immediately; after release, no redirect.
